// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - opcodes and state encoding shared by the register-file sequencer
package regfile_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - expands LOAD/MOV/SWAP commands into register-file read/write cycles
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] rf_data_out,
  output logic [AW-1:0] rf_readnum,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state;
  state_t        next_state;

  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] tmp_a;
  logic [DW-1:0] tmp_b;

  // State register; reset returns to IDLE so no write can follow an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing per command; start only counts in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD: next_state = S_WR1;
            OP_MOV:  next_state = S_RD1;
            OP_SWAP: next_state = S_RD1;
            default: next_state = S_DONE;
          endcase
        end
      end
      S_RD1:   next_state = (cmd_op == OP_SWAP) ? S_RD2 : S_WR1;
      S_RD2:   next_state = S_WR1;
      S_WR1:   next_state = (cmd_op == OP_SWAP) ? S_WR2 : S_DONE;
      S_WR2:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Latch the command once at acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_op  <= OP_LOAD;
      cmd_rd  <= '0;
      cmd_rs  <= '0;
      cmd_imm <= '0;
    end else if (state == S_IDLE && start) begin
      cmd_op  <= op;
      cmd_rd  <= rd;
      cmd_rs  <= rs;
      cmd_imm <= imm;
    end
  end

  // Read index is registered so it is valid for the whole RD cycle and holds afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_readnum <= '0;
    end else if (state == S_IDLE && next_state == S_RD1) begin
      rf_readnum <= (op == OP_SWAP) ? rd : rs;
    end else if (state == S_RD1 && next_state == S_RD2) begin
      rf_readnum <= cmd_rs;
    end
  end

  // Capture combinational read data at the edge that ends each RD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmp_a <= '0;
      tmp_b <= '0;
    end else if (state == S_RD1) begin
      tmp_a <= rf_data_out;
    end else if (state == S_RD2) begin
      tmp_b <= rf_data_out;
    end
  end

  // Moore outputs decoded from the state and the latched command.
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    err         = (state == S_DONE) && (cmd_op == OP_RSVD);
    rf_write    = (state == S_WR1) || (state == S_WR2);
    rf_writenum = (state == S_WR2) ? cmd_rs : cmd_rd;
    rf_data_in  = tmp_b;
    if (state == S_WR2) begin
      rf_data_in = tmp_a;
    end else begin
      case (cmd_op)
        OP_LOAD: rf_data_in = cmd_imm;
        OP_MOV:  rf_data_in = tmp_a;
        default: rf_data_in = tmp_b;
      endcase
    end
  end

endmodule
